uart_tx_fifo: RTL

Parametrised UART transmitter with an input FIFO. It serialises words onto tx_data as start bit, LSB-first data, optional parity, and one or two stop bits. Each bit lasts OVERSAMPLE clk_in cycles, so clk_in = OVERSAMPLE × baud. It sits between the PID telemetry/command logic and the board TX pin, and it sends queued words back-to-back without idle gaps.

---
 rtl/uart_tx_fifo.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO: start bit, LSB-first data,
// optional parity, one or two stop bits, frames sent back-to-back.
module uart_tx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_in,
  input  logic                          reset_n,
  input  logic                          send,
  input  logic [DATA_BITS-1:0]          send_data,
  input  logic                          clear_ovf,
  output logic                          send_rdy,
  output logic                          tx_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST  = IW'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [IW-1:0]          idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_reg, par_next;
  logic [AW:0]            count_reg, count_next;
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic                   ovf_reg, ovf_next;
  logic                   tx_reg, tx_next;
  logic                   busy_reg, busy_next;
  logic                   push, pop, cnt_last;
  logic [DATA_BITS-1:0]   rd_word;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

  assign send_rdy   = (count_reg != FULL_COUNT);
  assign push       = send && send_rdy;
  assign cnt_last   = (cnt_reg == CNT_LAST);
  assign rd_word    = mem[rd_ptr_reg];
  assign tx_data    = tx_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;
  assign overflow   = ovf_reg;

  // Storage is not reset; only words counted by count_reg are ever read.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_reg] <= send_data;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      par_reg    <= 1'b0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      par_reg    <= par_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      tx_reg     <= tx_next;
      busy_reg   <= busy_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = START;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
          if (idx_reg == DATA_LAST) begin
            idx_next   = '0;
            state_next = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            idx_next = idx_reg + IDX_ONE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      PARITY: begin
        if (cnt_last) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_next = '0;
          if (idx_reg == STOP_LAST) begin
            idx_next = '0;
            // Chain straight into the next start bit so queued words leave no gap.
            if (count_reg != '0) begin
              pop        = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx_reg + IDX_ONE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
    // Parity is captured with the word so later FIFO writes cannot disturb it.
    if (pop) begin
      shift_next = rd_word;
      par_next   = (PARITY_MODE == 2) ? ~^rd_word : ^rd_word;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase

    ovf_next = ovf_reg;
    if (clear_ovf) begin
      ovf_next = 1'b0;
    end
    if (send && !send_rdy) begin
      ovf_next = 1'b1;
    end

    // Line level is derived from the next state so tx_data comes from a flop.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE) || (count_next != '0);
  end

endmodule
